// File: rtl/uart_rcv_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rcv_param
//  Purpose  : UART receiver with run-time bit period, data length and parity
//             mode; good frames are queued in a small circular FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rcv_param #(
    parameter int MAX_DATA   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_W   = 14
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        serial_in,
    input  logic [PERIOD_W-1:0]         bit_period,
    input  logic [3:0]                  data_size,
    input  logic [1:0]                  parity_mode,
    input  logic                        data_read,
    output logic [MAX_DATA-1:0]         rx_data,
    output logic                        data_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun_error,
    output logic                        framing_error,
    output logic                        parity_error
);

    localparam int         PTR_W      = $clog2(FIFO_DEPTH);
    localparam int         CNT_W      = PTR_W + 1;
    localparam logic [4:0] C_MIN_SIZE = 5'd5;
    localparam logic [4:0] C_MAX_SIZE = 5'(MAX_DATA);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                sync1_q, sync2_q, prev_q;
    logic [2:0]          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic [4:0]          size_q, size_d, idx_q, idx_d;
    logic                par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                par_bad_q, par_bad_d;
    logic [MAX_DATA-1:0] shreg_q, shreg_d;
    logic                framing_q, framing_d, parity_q, parity_d;

    logic [MAX_DATA-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overrun_q;

    logic                w_line, w_fall, w_sample, w_ones, w_push;
    logic                w_pop, w_full, w_wr;
    logic [4:0]          w_size_ext, w_size_clamp;

    assign w_line       = sync2_q;
    assign w_fall       = prev_q & ~sync2_q;
    // Start bit is sampled half a period in; every later bit one full period on.
    assign w_sample     = (state_q == S_START) ? (cnt_q == (per_q >> 1)) : (cnt_q == per_q);
    assign w_ones       = (^shreg_q) ^ w_line;
    assign w_size_ext   = {1'b0, data_size};
    assign w_size_clamp = (w_size_ext < C_MIN_SIZE) ? C_MIN_SIZE :
                          (w_size_ext > C_MAX_SIZE) ? C_MAX_SIZE : w_size_ext;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame FSM state and per-frame latched configuration.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            size_q    <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bad_q <= 1'b0;
            shreg_q   <= '0;
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            size_q    <= size_d;
            idx_q     <= idx_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bad_q <= par_bad_d;
            shreg_q   <= shreg_d;
            framing_q <= framing_d;
            parity_q  <= parity_d;
        end
    end

    // Next-state logic: bit timing, data capture, parity and frame disposition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        size_d    = size_q;
        idx_d     = idx_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bad_d = par_bad_q;
        shreg_d   = shreg_q;
        framing_d = framing_q;
        parity_d  = parity_q;
        w_push    = 1'b0;

        // Counter restarts at 1 after each sample so the next lands a period later.
        if (state_q != S_IDLE) begin
            cnt_d = w_sample ? PERIOD_W'(1) : cnt_q + PERIOD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d   = S_START;
                    cnt_d     = PERIOD_W'(1);
                    per_d     = bit_period;
                    size_d    = w_size_clamp;
                    par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd_d = (parity_mode == 2'b01);
                    par_bad_d = 1'b0;
                    idx_d     = '0;
                    shreg_d   = '0;
                end
            end
            S_START: begin
                if (w_sample) begin
                    if (w_line) begin
                        state_d = S_IDLE;
                    end else begin
                        framing_d = 1'b0;
                        parity_d  = 1'b0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    for (int i = 0; i < MAX_DATA; i++) begin
                        if (idx_q == 5'(i)) begin
                            shreg_d[i] = w_line;
                        end
                    end
                    if (idx_q == size_q - 5'd1) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_sample) begin
                    par_bad_d = par_odd_q ? ~w_ones : w_ones;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    state_d = S_IDLE;
                    if (!w_line) begin
                        framing_d = 1'b1;
                    end
                    if (par_bad_q) begin
                        parity_d = 1'b1;
                    end
                    w_push = w_line & ~par_bad_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A push into a full FIFO still succeeds when a pop frees a slot that cycle.
    assign w_pop  = data_read && (count_q != '0);
    assign w_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_wr   = w_push && (!w_full || w_pop);

    // FIFO pointers, occupancy and overrun flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (w_pop) begin
                overrun_q <= 1'b0;
            end else if (w_push && w_full) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign data_ready    = (count_q != '0);
    assign rx_data       = data_ready ? mem_q[rd_ptr_q] : '0;
    assign fifo_count    = count_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;
    assign parity_error  = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rcv_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rcv_param
//  Purpose  : Self-checking bench for uart_rcv_param: a frame-level model
//             (expected FIFO queue and flags, updated at the cycles the frame
//             timing rules dictate) checked every cycle, plus literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rcv_param;

    localparam int MAXD  = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 14;

    logic            clk         = 1'b0;
    logic            n_rst       = 1'b0;
    logic            serial_in   = 1'b1;
    logic [PW-1:0]   bit_period  = 14'd10;
    logic [3:0]      data_size   = 4'd8;
    logic [1:0]      parity_mode = 2'b00;
    logic            data_read   = 1'b0;
    logic [MAXD-1:0] rx_data;
    logic            data_ready;
    logic [2:0]      fifo_count;
    logic            overrun_error;
    logic            framing_error;
    logic            parity_error;

    uart_rcv_param #(
        .MAX_DATA   (MAXD),
        .FIFO_DEPTH (DEPTH),
        .PERIOD_W   (PW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .bit_period    (bit_period),
        .data_size     (data_size),
        .parity_mode   (parity_mode),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .fifo_count    (fifo_count),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    // Scheduled model events: flag clear at the start-sample effect cycle,
    // disposition at the stop-sample effect cycle.
    typedef struct {
        int              at;
        bit              clr;
        bit              stop;
        bit              fe;
        bit              pe;
        bit              push;
        logic [MAXD-1:0] data;
    } ev_t;

    ev_t             sched[$];
    int              sched_rd = 0;
    int              cyc      = 0;
    logic [MAXD-1:0] m_q[$];
    bit              m_ovr    = 1'b0;
    bit              m_fe     = 1'b0;
    bit              m_pe     = 1'b0;
    int              n_cmp    = 0;
    int              n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_size(input int ds);
        if (ds < 5) return 5;
        if (ds > MAXD) return MAXD;
        return ds;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovr    = 1'b0;
        m_fe     = 1'b0;
        m_pe     = 1'b0;
        sched_rd = sched.size();
    endtask

    // Drives one frame; rst_bit >= 0 pulses reset half-way through that bit.
    task automatic send_frame(input logic [15:0] data, input bit pbit, input bit stopb,
                              input int rst_bit);
        int              t, h, n, ks, ones, p;
        bit              pen, pbad;
        bit              bits[$];
        logic [15:0]     sh;
        logic [MAXD-1:0] exp_val;
        ev_t             e;
        t       = int'(bit_period);
        h       = t / 2;
        n       = eff_size(int'(data_size));
        pen     = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        exp_val = MAXD'(data & ((16'd1 << n) - 16'd1));
        ones    = $countones(exp_val) + int'(pbit);
        pbad    = ((parity_mode == 2'b01) && (ones % 2 == 0)) ||
                  ((parity_mode == 2'b10) && (ones % 2 == 1));
        bits.push_back(1'b0);
        sh = data;
        for (int i = 0; i < n; i++) begin
            bits.push_back(sh[0]);
            sh = sh >> 1;
        end
        if (pen) bits.push_back(pbit);
        bits.push_back(stopb);
        ks = bits.size() - 1;
        p  = cyc;
        // Line low after edge p: sync 2, edge 1, start offset h, register 1.
        e.at = p + 3 + h; e.clr = 1'b1; e.stop = 1'b0; e.fe = 1'b0; e.pe = 1'b0;
        e.push = 1'b0; e.data = '0;
        sched.push_back(e);
        e.at = p + 3 + h + ks * t; e.clr = 1'b0; e.stop = 1'b1; e.fe = ~stopb; e.pe = pbad;
        e.push = stopb && !pbad; e.data = exp_val;
        sched.push_back(e);
        for (int k = 0; k <= ks; k++) begin
            serial_in = bits[k];
            if (k == rst_bit) begin
                repeat (h) tick();
                n_rst     = 1'b0;
                serial_in = 1'b1;
                #1;
                chk("rst_rx_data", rx_data, 0);
                chk("rst_data_ready", data_ready, 0);
                chk("rst_fifo_count", fifo_count, 0);
                chk("rst_overrun", overrun_error, 0);
                chk("rst_framing", framing_error, 0);
                tick();
                tick();
                n_rst = 1'b1;
                repeat (4) tick();
                return;
            end
            repeat (t) tick();
        end
        serial_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic read_check(input string nm, input logic [MAXD-1:0] exp);
        chk(nm, rx_data, exp);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
    endtask

    initial begin
        fork
            // Model: pops on data_read, then applies events due this cycle.
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
                if (!n_rst) begin
                    model_reset();
                end else begin
                    if (data_read && m_q.size() > 0) begin
                        void'(m_q.pop_front());
                        m_ovr = 1'b0;
                    end
                    while (sched_rd < sched.size() && sched[sched_rd].at <= cyc) begin
                        if (sched[sched_rd].clr) begin
                            m_fe = 1'b0;
                            m_pe = 1'b0;
                        end
                        if (sched[sched_rd].stop) begin
                            if (sched[sched_rd].fe) m_fe = 1'b1;
                            if (sched[sched_rd].pe) m_pe = 1'b1;
                            if (sched[sched_rd].push) begin
                                if (m_q.size() >= DEPTH) m_ovr = 1'b1;
                                else m_q.push_back(sched[sched_rd].data);
                            end
                        end
                        sched_rd++;
                    end
                end
            end
            forever begin
                @(negedge n_rst);
                model_reset();
            end
            // Per-cycle comparison against the model.
            forever begin
                @(negedge clk);
                chk("data_ready", data_ready, (m_q.size() != 0) ? 1 : 0);
                chk("fifo_count", fifo_count, m_q.size());
                chk("rx_data", rx_data, (m_q.size() != 0) ? m_q[0] : '0);
                chk("overrun_error", overrun_error, m_ovr);
                chk("framing_error", framing_error, m_fe);
                chk("parity_error", parity_error, m_pe);
            end
        join_none

        // Reset values
        repeat (3) tick();
        chk("reset_rx_data", rx_data, 0);
        chk("reset_data_ready", data_ready, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_flags", {overrun_error, framing_error, parity_error}, 0);
        n_rst = 1'b1;
        repeat (3) tick();

        // Basic 8N1 frame
        bit_period = 14'd10; data_size = 4'd8; parity_mode = 2'b00;
        send_frame(16'h00A5, 1'b0, 1'b1, -1);
        chk("a5_rx_data", rx_data, 8'hA5);
        chk("a5_fifo_count", fifo_count, 1);
        chk("a5_flags", {overrun_error, framing_error, parity_error}, 0);
        read_check("a5_read", 8'hA5);
        chk("a5_empty", data_ready, 0);

        // 7 bits, even then odd parity
        data_size = 4'd7; parity_mode = 2'b10;
        send_frame(16'h0035, 1'b0, 1'b1, -1);
        chk("even_good_count", fifo_count, 1);
        send_frame(16'h0035, 1'b1, 1'b1, -1);
        chk("even_bad_perr", parity_error, 1);
        chk("even_bad_count", fifo_count, 1);
        parity_mode = 2'b01;
        send_frame(16'h0007, 1'b0, 1'b1, -1);
        chk("odd_good_perr", parity_error, 0);
        chk("odd_good_count", fifo_count, 2);
        read_check("par_read0", 8'h35);
        read_check("par_read1", 8'h07);

        // Framing error, glitch, recovery
        data_size = 4'd8; parity_mode = 2'b00;
        send_frame(16'h003C, 1'b0, 1'b0, -1);
        chk("frame_ferr", framing_error, 1);
        chk("frame_count", fifo_count, 0);
        bit_period = 14'd16;
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (24) tick();
        chk("glitch_ferr_held", framing_error, 1);
        chk("glitch_count", fifo_count, 0);
        send_frame(16'h0011, 1'b0, 1'b1, -1);
        chk("recover_ferr", framing_error, 0);
        read_check("recover_read", 8'h11);

        // Data size clamping, odd bit period
        bit_period = 14'd9; data_size = 4'd3;
        send_frame(16'h00FF, 1'b0, 1'b1, -1);
        data_size = 4'd15;
        send_frame(16'h00C3, 1'b0, 1'b1, -1);
        read_check("clamp_low", 8'h1F);
        read_check("clamp_high", 8'hC3);

        // Overrun
        bit_period = 14'd10; data_size = 4'd8;
        for (int i = 1; i <= 5; i++) send_frame(16'(i), 1'b0, 1'b1, -1);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", overrun_error, 1);
        read_check("ovr_read1", 8'h01);
        chk("ovr_cleared", overrun_error, 0);
        read_check("ovr_read2", 8'h02);
        read_check("ovr_read3", 8'h03);
        read_check("ovr_read4", 8'h04);
        chk("ovr_drained", data_ready, 0);

        // Reset mid-DATA with two entries queued
        send_frame(16'h0021, 1'b0, 1'b1, -1);
        send_frame(16'h0042, 1'b0, 1'b1, -1);
        chk("pre_rst_count", fifo_count, 2);
        send_frame(16'h0099, 1'b0, 1'b1, 3);
        chk("post_rst_count", fifo_count, 0);
        send_frame(16'h005A, 1'b0, 1'b1, -1);
        chk("post_rst_count1", fifo_count, 1);
        read_check("post_rst_read", 8'h5A);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rcv_param.md
# uart_rcv_param

Parametrised UART receiver: recovers asynchronous serial frames with run-time programmable bit period, data length and parity mode, and queues good frames in an internal FIFO of configurable depth. It replaces the fixed 8-bit, single-buffer receive path in the UART subsystem, adds parity checking, false-start rejection and multi-frame buffering, and sits between the pad-side `serial_in` and the bus-side read logic.

## Interface
- `MAX_DATA`, 8: maximum data bits per frame; also the `rx_data` width (5..16).
- `FIFO_DEPTH`, 4: receive FIFO entries (power of two, 2..16).
- `PERIOD_W`, 14: width of `bit_period`.
- `clk`  in  1  system clock; the only clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `serial_in`  in  1  asynchronous serial line, idle high.
- `bit_period`  in  PERIOD_W  clk cycles per bit, minimum 4.
- `data_size`  in  4  data bits per frame.
- `parity_mode`  in  2  00/11 none, 01 odd, 10 even.
- `data_read`  in  1  pop FIFO head (one-cycle pulse).
- `rx_data`  out  MAX_DATA  FIFO head, right-justified, zero-filled above `data_size`.
- `data_ready`  out  1  FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `overrun_error`  out  1  good frame dropped because FIFO full.
- `framing_error`  out  1  last frame's stop bit sampled 0.
- `parity_error`  out  1  last frame's parity check failed.

## Operation
- `serial_in` passes through a 2-flop synchroniser (reset value 1). Falling-edge detect on the synchronised value (previous 1, current 0).
- FSM states IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on falling edge. Latch `bit_period`, clamped `data_size` and `parity_mode` for the whole frame.
  - START: sample at mid-bit. If the line is 1 (false start), return to IDLE with no flag change. Otherwise clear `framing_error` and `parity_error`, then go to DATA.
  - DATA: shift in `data_size` bits, LSB first.
  - DATA -> PARITY if parity is enabled, else DATA -> STOP.
  - PARITY: sample one bit. Odd mode requires odd total ones over data plus parity; even mode requires even.
  - STOP: sample one bit, then go to IDLE. Edge detection for the next frame is active from the next cycle.
- Clamping: `data_size` < 5 is treated as 5; `data_size` > `MAX_DATA` is treated as `MAX_DATA`.
- Frame disposition at the stop sample:
  - Stop bit 0: set `framing_error` and drop the frame.
  - Parity bad: set `parity_error` and drop the frame. Both flags may set together.
  - Good frame: push to the FIFO.
  - Error flags hold until the next valid start bit or reset.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - `data_read` with the FIFO empty is ignored.
  - Push when full is dropped and sets `overrun_error`.
  - A push and a pop in the same cycle while full both succeed; count is unchanged and `overrun_error` is not set.
  - `overrun_error` clears on the first `data_read` with the FIFO non-empty.
- Reset mid-frame: FSM returns to IDLE, the FIFO empties, and the partial frame is discarded.

## Timing
- Reset values: `rx_data`=0, `data_ready`=0, `fifo_count`=0, all error flags 0, FSM in IDLE.
- Sample timing, with detect cycle D (cycle the edge is seen at the synchroniser output) and H = `bit_period`>>1:
  - Start sample at D+H.
  - Each following sample at the previous sample + `bit_period`.
- Pushes and flag updates take effect the cycle after the stop sample. `data_ready` and `fifo_count` update in that same cycle.
- `rx_data` is valid whenever `data_ready`=1 and advances the cycle after a `data_read` pop.
- Error flags set the cycle after the stop sample and clear the cycle after a valid start sample.
- Total `serial_in`-to-`data_ready` latency: 2 (sync) + 1 (edge) + sample offsets + 1.
- Config inputs may change freely while in IDLE. Changes during a frame have no effect until the next frame.

## Test plan
- `bit_period`=10, `data_size`=8, parity none, send 0xA5 with stop=1 -> `data_ready`=1 the cycle after the stop sample, `rx_data`=0xA5, `fifo_count`=1, no errors.
- `data_size`=7, even parity, send 0x35 with parity bit 0 -> frame accepted. Send 0x35 with parity bit 1 -> `parity_error`=1, `fifo_count` unchanged. Next valid start clears the flag.
- Stop bit driven 0 on 0x3C -> `framing_error`=1 and the frame is dropped. A following good 0x11 clears the flag and is pushed.
- A 3-cycle low glitch with `bit_period`=16 -> FSM returns to IDLE, no push, no flags.
- `FIFO_DEPTH`=4, send 5 frames 0x01..0x05 without reads -> `fifo_count`=4, `overrun_error`=1. Reads return 0x01..0x04. The first read clears `overrun_error`.
- Assert `n_rst` low mid-DATA with 2 entries queued -> all outputs return to reset values. A subsequent frame 0x5A is received correctly.
